// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID stage and hazard_ctrl: decoded ID fields, EX branch
// resolution, and the pipeline hold/flush/bubble controls returned to the datapath.
interface hazard_ctrl_if #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_BITWIDTH     = 16
);
   logic                        id_valid;
   logic [REG_NUM_BITWIDTH-1:0] id_rs1;
   logic [REG_NUM_BITWIDTH-1:0] id_rs2;
   logic                        id_use_rs1;
   logic                        id_use_rs2;
   logic [REG_NUM_BITWIDTH-1:0] id_rd;
   logic                        id_regWrite;
   logic                        id_memRead;
   logic                        ex_branch_taken;
   logic                        pc_write;
   logic                        ifid_write;
   logic                        ifid_flush;
   logic                        idex_bubble;
   logic                        hazard_stall;
   logic [CNT_BITWIDTH-1:0]     stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_regWrite, id_memRead, ex_branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, hazard_stall, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_regWrite, id_memRead, ex_branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, hazard_stall, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: tracks EX/MEM destinations, stalls on RAW, squashes on taken branch.
// Define HAZARD_CTRL_FORWARD_EN when the datapath forwards from EX/MEM (only load-use then stalls).
module hazard_ctrl #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_BITWIDTH     = 16
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
);
   typedef struct packed {
      logic                        valid;
      logic [REG_NUM_BITWIDTH-1:0] rd;
      logic                        reg_write;
      logic                        mem_read;
   } slot_t;

   localparam slot_t                   SLOT_EMPTY = '0;
   localparam logic [CNT_BITWIDTH-1:0] CNT_ONE    = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

   slot_t                   r_ex;
   slot_t                   r_mem;
   logic [CNT_BITWIDTH-1:0] r_stall_cnt;
   logic                    w_flush;
   logic                    w_stall;
   logic                    w_ex_hit;
   logic                    w_mem_hit;

   function automatic logic f_match(input slot_t slot, input logic use_rs,
                                    input logic [REG_NUM_BITWIDTH-1:0] rs);
      return use_rs && (rs != '0) && slot.valid && slot.reg_write && (slot.rd == rs);
   endfunction

   assign w_ex_hit  = f_match(r_ex,  hz.id_use_rs1, hz.id_rs1) | f_match(r_ex,  hz.id_use_rs2, hz.id_rs2);
   assign w_mem_hit = f_match(r_mem, hz.id_use_rs1, hz.id_rs1) | f_match(r_mem, hz.id_use_rs2, hz.id_rs2);

   // A taken branch seen during reset must not leak out as a flush.
   assign w_flush = hz.ex_branch_taken & ~rst;

`ifdef HAZARD_CTRL_FORWARD_EN
   assign w_stall = hz.id_valid & ~w_flush & r_ex.mem_read & w_ex_hit;
`else
   assign w_stall = hz.id_valid & ~w_flush & (w_ex_hit | w_mem_hit);
`endif

   // NOTE: every output gets its idle value first so no path through the block infers a latch.
   always_comb begin
      hz.pc_write     = 1'b1;
      hz.ifid_write   = 1'b1;
      hz.ifid_flush   = 1'b0;
      hz.idex_bubble  = 1'b0;
      hz.hazard_stall = 1'b0;
      if (w_flush) begin
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (w_stall) begin
         hz.pc_write     = 1'b0;
         hz.ifid_write   = 1'b0;
         hz.idex_bubble  = 1'b1;
         hz.hazard_stall = 1'b1;
      end
   end

   assign hz.stall_cnt = r_stall_cnt;

   // NOTE: non-blocking assignments let MEM capture the EX contents from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex        <= SLOT_EMPTY;
         r_mem       <= SLOT_EMPTY;
         r_stall_cnt <= '0;
      end else begin
         r_mem <= r_ex;
         if (w_stall || w_flush) begin
            r_ex <= SLOT_EMPTY;
         end else begin
            r_ex.valid     <= hz.id_valid;
            r_ex.rd        <= hz.id_rd;
            r_ex.reg_write <= hz.id_regWrite;
            r_ex.mem_read  <= hz.id_memRead;
         end
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a 16-bit-counter DUT and a 4-bit-counter DUT share
// stimulus; a pipeline-history model is compared on every negedge, plus literal expectations.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef HAZARD_CTRL_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   hazard_ctrl_if #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(16)) hz16 ();
   hazard_ctrl_if #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(4))  hz4 ();

   hazard_ctrl #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz16.slave)
   );

   hazard_ctrl #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .hz  (hz4.slave)
   );

   assign hz4.id_valid        = hz16.id_valid;
   assign hz4.id_rs1          = hz16.id_rs1;
   assign hz4.id_rs2          = hz16.id_rs2;
   assign hz4.id_use_rs1      = hz16.id_use_rs1;
   assign hz4.id_use_rs2      = hz16.id_use_rs2;
   assign hz4.id_rd           = hz16.id_rd;
   assign hz4.id_regWrite     = hz16.id_regWrite;
   assign hz4.id_memRead      = hz16.id_memRead;
   assign hz4.ex_branch_taken = hz16.ex_branch_taken;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the instructions that left ID on the last two clocks (0 = now in EX, 1 = now in MEM).
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } rec_t;

   rec_t hist [2] = '{default: '0};
   int   m_cnt16 = 0;
   int   m_cnt4  = 0;

   function automatic void m_eval(output logic flush, output logic stall);
      logic hit;
      int   window;
      hit    = 1'b0;
      window = FWD ? 1 : 2;
      flush  = hz16.ex_branch_taken && !rst;
      for (int age = 0; age < window; age++) begin
         if (hist[age].valid && hist[age].wr && hist[age].rd != 5'd0 && (!FWD || hist[age].ld)) begin
            if (hz16.id_use_rs1 && hz16.id_rs1 == hist[age].rd) hit = 1'b1;
            if (hz16.id_use_rs2 && hz16.id_rs2 == hist[age].rd) hit = 1'b1;
         end
      end
      stall = hz16.id_valid && !flush && !rst && hit;
   endfunction

   always @(posedge clk or posedge rst) begin : model_update
      logic f, s;
      if (rst) begin
         hist[0] <= '0;
         hist[1] <= '0;
         m_cnt16 <= 0;
         m_cnt4  <= 0;
      end else begin
         m_eval(f, s);
         if (s) begin
            m_cnt16 <= (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
            m_cnt4  <= (m_cnt4 == 15) ? 15 : m_cnt4 + 1;
         end
         hist[1] <= hist[0];
         hist[0] <= (s || f) ? rec_t'(0)
                             : {hz16.id_valid, hz16.id_rd, hz16.id_regWrite, hz16.id_memRead};
      end
   end

   always @(negedge clk) begin : compare
      logic f, s;
      m_eval(f, s);
      check("pc_write",       hz16.pc_write,     !s);
      check("ifid_write",     hz16.ifid_write,   !s);
      check("ifid_flush",     hz16.ifid_flush,   f);
      check("idex_bubble",    hz16.idex_bubble,  f | s);
      check("hazard_stall",   hz16.hazard_stall, s);
      check("stall_cnt16",    hz16.stall_cnt,    m_cnt16);
      check("sat_stall",      hz4.hazard_stall,  s);
      check("sat_stall_cnt4", hz4.stall_cnt,     m_cnt4);
   end

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
      hz16.id_valid    = v;
      hz16.id_rs1      = rs1;
      hz16.id_use_rs1  = u1;
      hz16.id_rs2      = rs2;
      hz16.id_use_rs2  = u2;
      hz16.id_rd       = rd;
      hz16.id_regWrite = wr;
      hz16.id_memRead  = ld;
   endtask

   logic first_pc_write, first_ifid_write, first_idex_bubble, first_stall;

   // Hold the current ID instruction until it leaves ID; returns the stall cycles seen.
   task automatic issue(output int n_stall);
      n_stall = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) begin
            first_pc_write    = hz16.pc_write;
            first_ifid_write  = hz16.ifid_write;
            first_idex_bubble = hz16.idex_bubble;
            first_stall       = hz16.hazard_stall;
         end
         if (!hz16.hazard_stall) begin
            @(posedge clk); #1;
            return;
         end
         n_stall++;
         @(posedge clk); #1;
      end
      total++;
      bad++;
      $display("FAIL issue_budget: stall still high after %0d cycles", n_stall);
   endtask

   task automatic drain();
      int n;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      repeat (3) issue(n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hz16.ex_branch_taken = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [4:0] p_rd;
      logic       p_wr;
      logic       p_ld;
      int         gap;
      logic       c_valid;
      logic [4:0] c_rs1;
      logic       c_u1;
      logic [4:0] c_rs2;
      logic       c_u2;
      int         exp_fwd;
      int         exp_nofwd;
   } vec_t;

   vec_t vecs [10];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      int sat_stalls;

      // 1: reset holds outputs idle even with a taken branch and a live ID instruction
      rst = 1'b1;
      hz16.ex_branch_taken = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      check("rst_pc_write",   hz16.pc_write,     1);
      check("rst_ifid_flush", hz16.ifid_flush,   0);
      check("rst_bubble",     hz16.idex_bubble,  0);
      check("rst_stall_cnt",  hz16.stall_cnt,    0);
      @(posedge clk); #1;
      rst = 1'b0;
      hz16.ex_branch_taken = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      check("idle_pc_write",  hz16.pc_write,     1);
      check("idle_stall",     hz16.hazard_stall, 0);
      @(posedge clk); #1;

      // 2/3: producer -> optional nops -> consumer, stall cycles hand-counted per build
      //                p_rd  wr  ld  gap  cv  rs1  u1  rs2  u2   fwd nofwd
      vecs[0] = '{5'd5,  1, 1,  0,  1, 5'd5,  1, 5'd7,  1,  1, 2}; // lw x5; add x6,x5,x7
      vecs[1] = '{5'd5,  1, 0,  0,  1, 5'd5,  1, 5'd5,  1,  0, 2}; // addi x5; add x6,x5,x5
      vecs[2] = '{5'd0,  1, 0,  0,  1, 5'd0,  1, 5'd0,  1,  0, 0}; // addi x0; add x6,x0,x0
      vecs[3] = '{5'd0,  1, 1,  0,  1, 5'd0,  1, 5'd0,  1,  0, 0}; // lw x0; use x0
      vecs[4] = '{5'd9,  1, 1,  1,  1, 5'd1,  1, 5'd9,  1,  0, 1}; // lw x9; nop; use rs2=x9
      vecs[5] = '{5'd3,  1, 0,  2,  1, 5'd3,  1, 5'd0,  0,  0, 0}; // addi x3; 2 nops; use x3
      vecs[6] = '{5'd4,  1, 1,  0,  1, 5'd4,  0, 5'd4,  0,  0, 0}; // lw x4; sources unused
      vecs[7] = '{5'd8,  0, 0,  0,  1, 5'd8,  1, 5'd0,  0,  0, 0}; // store; no rd write
      vecs[8] = '{5'd11, 1, 1,  0,  1, 5'd2,  1, 5'd11, 1,  1, 2}; // lw x11; use rs2=x11
      vecs[9] = '{5'd5,  1, 1,  0,  0, 5'd5,  1, 5'd5,  1,  0, 0}; // lw x5; bubble in ID

      for (int v = 0; v < 10; v++) begin
         drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, vecs[v].p_rd, vecs[v].p_wr, vecs[v].p_ld);
         issue(n);
         for (int g = 0; g < vecs[v].gap; g++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            issue(n);
         end
         drive(vecs[v].c_valid, vecs[v].c_rs1, vecs[v].c_u1, vecs[v].c_rs2, vecs[v].c_u2,
               5'd6, 1'b1, 1'b0);
         issue(n);
         check($sformatf("vec%0d_stalls", v), n, FWD ? vecs[v].exp_fwd : vecs[v].exp_nofwd);
         if (v == 0) begin
            check("lu_first_stall",  first_stall,       1);
            check("lu_first_pc",     first_pc_write,    0);
            check("lu_first_ifid",   first_ifid_write,  0);
            check("lu_first_bubble", first_idex_bubble, 1);
            check("lu_stall_cnt",    hz16.stall_cnt,    FWD ? 1 : 2);
         end
         drain();
      end
      check("table_stall_cnt", hz16.stall_cnt, FWD ? 2 : 7);

      // 4: taken branch beats a load-use hazard
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      issue(n);
      drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
      hz16.ex_branch_taken = 1'b1;
      @(negedge clk);
      check("br_ifid_flush", hz16.ifid_flush,   1);
      check("br_bubble",     hz16.idex_bubble,  1);
      check("br_stall",      hz16.hazard_stall, 0);
      check("br_pc_write",   hz16.pc_write,     1);
      @(posedge clk); #1;
      hz16.ex_branch_taken = 1'b0;
      drive(1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      check("br_after_stall", hz16.hazard_stall, 0);
      @(posedge clk); #1;
      drain();

      // 5: saturation, self-dependent load chain lw x5,0(x5)
      do_reset();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      sat_stalls = 0;
      for (int c = 0; c < 200 && sat_stalls < 23; c++) begin
         @(negedge clk);
         if (hz16.hazard_stall) sat_stalls++;
         @(posedge clk); #1;
         if (sat_stalls == 20 && hz16.hazard_stall == 1'b0 && hz4.stall_cnt == 4'd15) begin
         end
         if (c == 199) begin
            total++;
            bad++;
            $display("FAIL sat_budget: only %0d stall cycles", sat_stalls);
         end
         if (sat_stalls == 20 && hz16.stall_cnt == 16'd20) begin
            check("sat_cnt4_at20", hz4.stall_cnt, 15);
         end
      end
      check("sat_cnt4_hold", hz4.stall_cnt,  15);
      check("sat_cnt16",     hz16.stall_cnt, 23);
      drain();

      // 6: async reset in the first stall cycle
      do_reset();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      issue(n);
      drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      check("mid_pre_stall", hz16.hazard_stall, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_stall",  hz16.hazard_stall, 0);
      check("mid_rst_pc",     hz16.pc_write,     1);
      check("mid_rst_ifid",   hz16.ifid_write,   1);
      check("mid_rst_bubble", hz16.idex_bubble,  0);
      check("mid_rst_cnt",    hz16.stall_cnt,    0);
      @(posedge clk); #1;
      rst = 1'b0;
      issue(n);
      check("mid_after_stalls", n, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
